// File: rtl/x1_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | x1_bus_pkg : shared state encoding and defaults for x1_bus_arb       |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package x1_bus_pkg;

   localparam int unsigned c_cnt_w         = 8;
   localparam int unsigned c_grant_timeout = 255;
   localparam int unsigned c_min_cpu_ce    = 4;
   localparam logic [7:0]  c_load_index    = 8'h00;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_DMA  = 3'd2,
      ST_REL  = 3'd3,
      ST_LREQ = 3'd4,
      ST_LOAD = 3'd5,
      ST_LREL = 3'd6
   } arb_state_e;

   function automatic logic is_load_target(input logic       download,
                                           input logic [7:0] index,
                                           input logic [7:0] target);
      return download && (index == target);
   endfunction

endpackage
`default_nettype wire

// File: rtl/x1_ce_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | x1_ce_counter : loadable ce-tick down-counter, saturates at zero     |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module x1_ce_counter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic             ce,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             zero
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk_sys or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_val;
      end else if (ce && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/x1_bus_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | x1_bus_arb : Z80 bus arbiter between CPU, DMA engine and RAM loader  |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module x1_bus_arb
   import x1_bus_pkg::*;
#(
   parameter int unsigned GRANT_TIMEOUT = c_grant_timeout,
   parameter int unsigned MIN_CPU_CE    = c_min_cpu_ce,
   parameter logic [7:0]  LOAD_INDEX    = c_load_index
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       ce,
   input  logic       cpu_busak_n,
   output logic       cpu_busrq_n,
   input  logic       dma_busrq_n,
   output logic       dma_busak_n,
   output logic       dma_sel,
   input  logic       ioctl_download,
   input  logic       ioctl_wr,
   input  logic [7:0] ioctl_index,
   output logic       load_sel,
   output logic       load_we,
   output logic       timeout_err,
   output logic [2:0] state_o
);

   localparam logic [c_cnt_w-1:0] c_tmo_val  = c_cnt_w'(GRANT_TIMEOUT);
   localparam logic [c_cnt_w-1:0] c_fair_val = c_cnt_w'(MIN_CPU_CE);

   arb_state_e r_state;
   arb_state_e w_next;
   logic       r_dma_sel;
   logic       r_load_sel;
   logic       r_timeout_err;
   logic       w_tmo_load;
   logic       w_fair_load;
   logic       w_tmo_zero;
   logic       w_fair_zero;
   logic       w_set_err;
   logic       w_load_hit;
   logic       w_bus_held;

   assign w_load_hit = is_load_target(ioctl_download, ioctl_index, LOAD_INDEX);

   x1_ce_counter #(.WIDTH(c_cnt_w)) u_tmo_cnt (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .ce       (ce),
      .load     (w_tmo_load),
      .load_val (c_tmo_val),
      .zero     (w_tmo_zero)
   );

   x1_ce_counter #(.WIDTH(c_cnt_w)) u_fair_cnt (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .ce       (ce),
      .load     (w_fair_load),
      .load_val (c_fair_val),
      .zero     (w_fair_zero)
   );

   always_comb begin
      w_next      = r_state;
      w_tmo_load  = 1'b0;
      w_fair_load = 1'b0;
      w_set_err   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // A matching download always beats a DMA request in the same cycle
            if (w_load_hit) begin
               w_next = ST_LREQ;
            end else if (!dma_busrq_n && w_fair_zero) begin
               w_next     = ST_REQ;
               w_tmo_load = 1'b1;
            end
         end
         ST_REQ: begin
            if (!cpu_busak_n) begin
               w_next = ST_DMA;
            end else if (dma_busrq_n) begin
               w_next = ST_REL;
            end else if (w_tmo_zero) begin
               w_next    = ST_REL;
               w_set_err = 1'b1;
            end
         end
         ST_DMA: begin
            if (dma_busrq_n) begin
               w_next = ST_REL;
            end
         end
         ST_REL: begin
            if (cpu_busak_n) begin
               w_fair_load = 1'b1;
               w_next      = w_load_hit ? ST_LREQ : ST_IDLE;
            end
         end
         ST_LREQ: begin
            if (!cpu_busak_n) begin
               w_next = ST_LOAD;
            end else if (!ioctl_download) begin
               w_next = ST_LREL;
            end
         end
         ST_LOAD: begin
            if (!ioctl_download) begin
               w_next = ST_LREL;
            end
         end
         ST_LREL: begin
            if (cpu_busak_n) begin
               w_fair_load = 1'b1;
               w_next      = ST_IDLE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_IDLE;
         r_dma_sel     <= 1'b0;
         r_load_sel    <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_dma_sel  <= (w_next == ST_DMA);
         r_load_sel <= (w_next == ST_LOAD);
         if (w_set_err) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   // Grants are additionally qualified by the CPU still holding the bus released
   assign w_bus_held  = ~cpu_busak_n;
   assign dma_sel     = r_dma_sel & w_bus_held;
   assign dma_busak_n = ~dma_sel;
   assign load_sel    = r_load_sel & w_bus_held;
   assign load_we     = ioctl_wr & load_sel & (ioctl_index == LOAD_INDEX);
   assign cpu_busrq_n = ~(r_state inside {ST_REQ, ST_DMA, ST_LREQ, ST_LOAD});
   assign timeout_err = r_timeout_err;
   assign state_o     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_x1_bus_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_x1_bus_arb : self-checking bench for x1_bus_arb                   |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module tb_x1_bus_arb;

   logic       clk_sys = 1'b0;
   logic       reset   = 1'b0;
   logic       ce, cpu_busak_n, dma_busrq_n, ioctl_download, ioctl_wr;
   logic [7:0] ioctl_index;
   logic       cpu_busrq_n, dma_busak_n, dma_sel, load_sel, load_we, timeout_err;
   logic [2:0] state_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       dma_n;
      logic       busak_n;
      logic       dl;
      logic       wr;
      logic [7:0] idx;
      logic [2:0] st;
      logic       busrq_n;
      logic       dsel;
      logic       lsel;
      logic       we;
   } vec_t;

   vec_t tbl[$];

   // reference model of bus ownership for the random phase
   bit m_ask, m_grant, m_rel, m_load_cool;
   int m_cool;
   int ticks;
   bit seen;

   always #5 clk_sys = ~clk_sys;

   x1_bus_arb dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .ce             (ce),
      .cpu_busak_n    (cpu_busak_n),
      .cpu_busrq_n    (cpu_busrq_n),
      .dma_busrq_n    (dma_busrq_n),
      .dma_busak_n    (dma_busak_n),
      .dma_sel        (dma_sel),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_index    (ioctl_index),
      .load_sel       (load_sel),
      .load_we        (load_we),
      .timeout_err    (timeout_err),
      .state_o        (state_o)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         if (errors <= 20)
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic do_reset();
      reset          = 1'b0;
      dma_busrq_n    = 1'b1;
      cpu_busak_n    = 1'b1;
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      ioctl_index    = 8'h00;
      ce             = 1'b1;
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic add(input logic dn, input logic bk, input logic dl, input logic wr,
                      input logic [7:0] idx, input logic [2:0] st, input logic rq,
                      input logic ds, input logic ls, input logic we);
      vec_t v;
      v.dma_n = dn; v.busak_n = bk; v.dl = dl; v.wr = wr; v.idx = idx;
      v.st = st; v.busrq_n = rq; v.dsel = ds; v.lsel = ls; v.we = we;
      tbl.push_back(v);
   endtask

   initial begin
      dma_busrq_n = 1'b1; cpu_busak_n = 1'b1; ioctl_download = 1'b0;
      ioctl_wr = 1'b0; ioctl_index = 8'h00; ce = 1'b1;
      #1;
      chk("rst busrq_n", cpu_busrq_n, 1);
      chk("rst dma_busak_n", dma_busak_n, 1);
      chk("rst dma_sel", dma_sel, 0);
      chk("rst load_sel", load_sel, 0);
      chk("rst load_we", load_we, 0);
      chk("rst timeout_err", timeout_err, 0);
      chk("rst state", state_o, 0);

      // dma_n busak dl wr idx | state busrq_n dsel lsel we  (ce=1 every cycle)
      add(1,1,0,0,0, 0,1,0,0,0);
      add(0,1,0,0,0, 1,0,0,0,0);
      add(0,1,0,0,0, 1,0,0,0,0);
      add(0,1,0,0,0, 1,0,0,0,0);
      add(0,0,0,0,0, 2,0,1,0,0);
      add(0,0,0,0,0, 2,0,1,0,0);
      add(1,0,0,0,0, 3,1,0,0,0);
      add(1,0,0,0,0, 3,1,0,0,0);
      add(1,1,0,0,0, 0,1,0,0,0);
      // immediate re-request: CPU keeps the bus for 4 ce ticks
      add(0,1,0,0,0, 0,1,0,0,0);
      add(0,1,0,0,0, 0,1,0,0,0);
      add(0,1,0,0,0, 0,1,0,0,0);
      add(0,1,0,0,0, 0,1,0,0,0);
      add(0,1,0,0,0, 1,0,0,0,0);
      add(1,1,0,0,0, 3,1,0,0,0);
      add(1,1,0,0,0, 0,1,0,0,0);
      add(1,1,0,0,0, 0,1,0,0,0);
      add(1,1,0,0,0, 0,1,0,0,0);
      add(1,1,0,0,0, 0,1,0,0,0);
      add(1,1,0,0,0, 0,1,0,0,0);
      // download and DMA in the same cycle: download first
      add(0,1,1,0,0, 4,0,0,0,0);
      add(0,0,1,0,0, 5,0,0,1,0);
      add(0,0,1,1,0, 5,0,0,1,1);
      add(0,0,1,0,0, 5,0,0,1,0);
      add(0,0,0,0,0, 6,1,0,0,0);
      add(0,1,0,0,0, 0,1,0,0,0);
      add(0,1,0,0,0, 0,1,0,0,0);
      add(0,1,0,0,0, 0,1,0,0,0);
      add(0,1,0,0,0, 0,1,0,0,0);
      add(0,1,0,0,0, 0,1,0,0,0);
      add(0,1,0,0,0, 1,0,0,0,0);
      add(0,0,0,0,0, 2,0,1,0,0);
      add(1,0,0,0,0, 3,1,0,0,0);
      add(1,1,0,0,0, 0,1,0,0,0);
      // non-matching index: ignored
      add(1,1,1,1,1, 0,1,0,0,0);
      add(1,1,1,1,1, 0,1,0,0,0);
      add(1,1,0,0,0, 0,1,0,0,0);
      // download arriving during DMA waits, then follows REL directly
      add(0,1,0,0,0, 0,1,0,0,0);
      add(0,1,0,0,0, 1,0,0,0,0);
      add(0,0,0,0,0, 2,0,1,0,0);
      add(0,0,1,0,0, 2,0,1,0,0);
      add(1,0,1,0,0, 3,1,0,0,0);
      add(1,1,1,0,0, 4,0,0,0,0);
      add(1,0,1,0,0, 5,0,0,1,0);
      add(1,0,0,0,0, 6,1,0,0,0);
      add(1,1,0,0,0, 0,1,0,0,0);

      do_reset();
      foreach (tbl[i]) begin
         dma_busrq_n    = tbl[i].dma_n;
         cpu_busak_n    = tbl[i].busak_n;
         ioctl_download = tbl[i].dl;
         ioctl_wr       = tbl[i].wr;
         ioctl_index    = tbl[i].idx;
         ce             = 1'b1;
         step();
         chk($sformatf("vec%0d state", i), state_o, tbl[i].st);
         chk($sformatf("vec%0d busrq_n", i), cpu_busrq_n, tbl[i].busrq_n);
         chk($sformatf("vec%0d dma_sel", i), dma_sel, tbl[i].dsel);
         chk($sformatf("vec%0d dma_busak_n", i), dma_busak_n, !tbl[i].dsel);
         chk($sformatf("vec%0d load_sel", i), load_sel, tbl[i].lsel);
         chk($sformatf("vec%0d load_we", i), load_we, tbl[i].we);
      end

      // grant timeout with ce on alternate cycles
      do_reset();
      ce = 1'b0; dma_busrq_n = 1'b0;
      step();
      chk("tmo enter req", state_o, 1);
      ticks = 0; seen = 1'b0;
      for (int i = 0; i < 1200 && !seen; i++) begin
         ce = (i % 2 == 0);
         step();
         if (ce) ticks++;
         if (timeout_err) seen = 1'b1;
      end
      chk("tmo seen", seen, 1);
      chk("tmo ce ticks", ticks, 255);
      chk("tmo busrq_n", cpu_busrq_n, 1);
      chk("tmo state rel", state_o, 3);
      dma_busrq_n = 1'b1; ce = 1'b1;
      step();
      chk("tmo state idle", state_o, 0);
      step();
      step();
      chk("tmo sticky", timeout_err, 1);

      // asynchronous reset while a DMA grant is active
      do_reset();
      chk("err cleared by reset", timeout_err, 0);
      dma_busrq_n = 1'b0;
      step();
      chk("ar req", state_o, 1);
      cpu_busak_n = 1'b0;
      step();
      chk("ar dma_sel", dma_sel, 1);
      #2 reset = 1'b0;
      #1;
      chk("ar async dma_sel", dma_sel, 0);
      chk("ar async busrq_n", cpu_busrq_n, 1);
      chk("ar async dma_busak_n", dma_busak_n, 1);
      chk("ar async state", state_o, 0);
      dma_busrq_n = 1'b1; cpu_busak_n = 1'b1;
      step();
      reset = 1'b1;

      // randomized traffic against the ownership model
      do_reset();
      m_ask = 0; m_grant = 0; m_rel = 0; m_cool = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         step();
         m_load_cool = 1'b0;
         if (m_grant) begin
            if (dma_busrq_n) begin m_grant = 0; m_rel = 1; end
         end else if (m_ask) begin
            if (!cpu_busak_n) begin m_ask = 0; m_grant = 1; end
            else if (dma_busrq_n) begin m_ask = 0; m_rel = 1; end
         end else if (m_rel) begin
            if (cpu_busak_n) begin m_rel = 0; m_load_cool = 1'b1; end
         end else if (!dma_busrq_n && m_cool == 0) begin
            m_ask = 1;
         end
         if (m_load_cool) m_cool = 4;
         else if (ce && m_cool > 0) m_cool--;

         chk("rnd busrq_n", cpu_busrq_n, !(m_ask || m_grant));
         chk("rnd dma_sel", dma_sel, m_grant);
         chk("rnd dma_busak_n", dma_busak_n, !m_grant);
         chk("rnd load_sel", load_sel, 0);
         chk("rnd load_we", load_we, 0);
         chk("rnd timeout_err", timeout_err, 0);

         if (cpu_busak_n != cpu_busrq_n && $urandom_range(0, 1) == 1)
            cpu_busak_n = cpu_busrq_n;
         if (dma_busrq_n) begin
            if ($urandom_range(0, 2) == 0) dma_busrq_n = 1'b0;
         end else if (dma_sel) begin
            if ($urandom_range(0, 3) == 0) dma_busrq_n = 1'b1;
         end else if ($urandom_range(0, 15) == 0) begin
            dma_busrq_n = 1'b1;
         end
         ioctl_download = 1'($urandom_range(0, 1));
         ioctl_wr       = 1'($urandom_range(0, 1));
         ioctl_index    = 8'($urandom_range(1, 255));
         ce             = 1'($urandom_range(0, 1));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
